// File: rtl/mul_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mul_issue_ctrl_pkg : shared opcodes, widths and helpers for the M-ext multiplier
// Revision: 1.0
// ============================================================================
package mul_issue_ctrl_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam int MUL_LAT = 3;
    localparam int DATA_W  = 32;
    localparam int OPND_W  = 33;
    localparam int PROD_W  = 64;

    // Widens a 32-bit operand to the tree's 33-bit signed form.
    function automatic logic [OPND_W-1:0] cond_operand(input logic [DATA_W-1:0] v,
                                                       input logic              sext);
        return {sext & v[DATA_W-1], v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_result_fifo.sv
`default_nettype none
// ============================================================================
// mul_result_fifo : in-order result buffer with flush clear and occupancy count
// Revision: 1.0
// ============================================================================
module mul_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [W-1:0]     i_wr_data,
    input  logic             i_rd_en,
    output logic [W-1:0]     o_rd_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_rd;

    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_rd      = i_rd_en && !o_empty;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_wr_en, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Credit admission upstream must make this unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && !i_flush) begin
            assert (!(i_wr_en && !w_rd && r_count == CNT_W'(DEPTH)))
                else $error("mul_result_fifo overflow");
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// mul_issue_ctrl : credit-based issue, stage tracking and final add for the
//                  2-stage Wallace-tree multiplier
// Revision: 1.0
// ============================================================================
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int TAG_W     = 5,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [32:0]       tree_a,
    output logic [32:0]       tree_b,
    output logic              tree_cancel,
    input  logic [63:0]       tree_sum,
    input  logic [63:0]       tree_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int IF_W  = CNT_W + 1;
    localparam int FW    = DATA_W + TAG_W;

    logic [OPND_W-1:0] r_tree_a;
    logic [OPND_W-1:0] r_tree_b;
    logic              r_e0_v;
    logic              r_e0_hi;
    logic [TAG_W-1:0]  r_e0_tag;
    logic              r_e1_v;
    logic              r_e1_hi;
    logic [TAG_W-1:0]  r_e1_tag;

    logic              w_accept;
    logic              w_sa;
    logic              w_sb;
    logic [IF_W-1:0]   w_inflight;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic [PROD_W-1:0] w_prod;
    logic [DATA_W-1:0] w_res;
    logic [FW-1:0]     w_head;

    assign w_sa = (in_op == MUL_OP_MULH) || (in_op == MUL_OP_MULHSU);
    assign w_sb = (in_op == MUL_OP_MULH);

    // Credits count everything that will eventually need a FIFO slot.
    assign w_inflight = IF_W'(r_e0_v) + IF_W'(r_e1_v) + IF_W'(w_count);
    assign in_ready   = (w_inflight < IF_W'(RES_DEPTH)) && !flush;
    assign w_accept   = in_valid && in_ready;

    assign tree_cancel = flush;
    assign tree_a      = r_tree_a;
    assign tree_b      = r_tree_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tree_a <= '0;
            r_tree_b <= '0;
            r_e0_v   <= 1'b0;
            r_e0_hi  <= 1'b0;
            r_e0_tag <= '0;
            r_e1_v   <= 1'b0;
            r_e1_hi  <= 1'b0;
            r_e1_tag <= '0;
        end else begin
            r_e0_v   <= w_accept;
            r_e1_v   <= r_e0_v & ~flush;
            r_e1_hi  <= r_e0_hi;
            r_e1_tag <= r_e0_tag;
            // Operands hold while idle; the tree's stale output is masked by r_e1_v.
            if (w_accept) begin
                r_tree_a <= cond_operand(in_a, w_sa);
                r_tree_b <= cond_operand(in_b, w_sb);
                r_e0_hi  <= (in_op != MUL_OP_MUL);
                r_e0_tag <= in_tag;
            end
        end
    end

    assign w_prod = tree_sum + tree_carry;
    assign w_res  = r_e1_hi ? w_prod[63:32] : w_prod[31:0];

    assign out_valid = !w_empty && !flush;
    assign out_data  = w_head[DATA_W-1:0];
    assign out_tag   = w_head[DATA_W +: TAG_W];

    mul_result_fifo #(
        .DEPTH (RES_DEPTH),
        .W     (FW),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (flush),
        .i_wr_en   (r_e1_v),
        .i_wr_data ({r_e1_tag, w_res}),
        .i_rd_en   (out_valid && out_ready),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_empty   (w_empty)
    );

endmodule
`default_nettype wire
